philo_ring: RTL and testbench
=============================

// Module: philo_ring
// PURPOSE
//  Parametrised ring of N dining/reading philosophers for model-checking benches.
//  Successor to the fixed 16-node ring:
//  - synthesizable, with explicit coin inputs and a synchronous reset;
//  - per-node starvation counters;
//  - optional fairness mode;
//  - mutual-exclusion error flags.
//  Sits at top of the philosopher model; checkers watch st/starving/excl_err.
// PARAMETERS
//  N            16  number of philosophers in ring (>=3)
//  READER_IDX   0   node that resets to READING; all others reset to THINKING
//  STARVE_LIMIT 8   hunger cycles before node flagged starving (>=1)
//  CW           4   counter width, must satisfy 2**CW > STARVE_LIMIT
//  FAIR_MODE    0   0 = classic protocol; 1 = neighbours yield to starving node
// PORTS
//  clock     in   1    single clock, posedge
//  reset_n   in   1    synchronous, active-low reset
//  coin      in   N    per-node nondeterministic choice bit (free input in formal)
//  st        out  2*N  node states, st[2i+1:2i] = node i
//  starving  out  N    node i hungry counter == STARVE_LIMIT
//  excl_err  out  N    node i and its left neighbour both EATING
// BEHAVIOUR
//  Encoding: THINKING=0, READING=1, EATING=2, HUNGRY=3.
//  Ring: left(i)=(i+1)%N, right(i)=(i+N-1)%N; node N-1 left is node 0.
//  Reset (reset_n==0 at posedge):
//  - st[READER_IDX]=READING, others THINKING; counters=0.
//  - starving=0, excl_err=0 on the cycle after reset.
//  - Reset mid-operation overrides any transition that cycle.
//  Per-node next state, all nodes update simultaneously from registered neighbour states:
//  - READING:  left==THINKING -> THINKING, else hold.
//  - THINKING: right==READING -> READING (coin ignored);
//              else coin ? THINKING : HUNGRY.
//  - EATING:   coin ? THINKING : EATING.
//  - HUNGRY:   go EATING iff left!=EATING && right!=HUNGRY && right!=EATING && !yield,
//              else hold.
//  yield:
//  - FAIR_MODE==0: yield=0.
//  - FAIR_MODE==1: yield = !starving[i] && (starving[left] || starving[right]).
//  - Two starving neighbours: no yield, classic rule arbitrates.
//  Hunger counter (CW bits):
//  - Increments each cycle node is HUNGRY and stays HUNGRY.
//  - Saturates at STARVE_LIMIT, never wraps.
//  - Cleared when node leaves HUNGRY (to EATING) or is not HUNGRY.
//  Outputs:
//  - st is the registered state, zero latency from the flop.
//  - starving is registered-counter compare, combinational only from flops.
//  - excl_err[i] = st[i]==EATING && st[left(i)]==EATING; a protocol violation,
//    never expected high.
//  No handshakes; one transition per node per clock.
// STRUCTURE
//  Package philo_pkg:
//  - state typedef (2-bit enum) and the four encoding constants;
//  - function next_state(self, left, right, coin, yield).
//  Sub-module philo_cell: one node, containing
//  - state reg, hunger counter, starving flag;
//  - ports: clock, reset_n, coin, left, right, nb_starving[1:0], init, st, starving.
//  philo_ring: generate loop of N philo_cell, ring wiring with modulo indices,
//  excl_err compare logic.
// TESTING
//  1. N=4, reset 2 cycles -> st=8'b00_00_00_01, starving=0, excl_err=0.
//  2. Token pass, N=4, coin=4'b1111 after reset:
//     cycle1 st=8'b00_00_01_00; cycle2 st=8'b00_01_00_00;
//     node 3 -> node 0 wrap at cycle4.
//  3. Starvation, N=4, STARVE_LIMIT=3:
//     - hold node 3 EATING (coin[3]=0), force node 0 HUNGRY;
//     - starving[0]=1 exactly 3 cycles after entering HUNGRY;
//     - counter stays 3 while held.
//  4. Fairness, FAIR_MODE=1, node 1 starving and node 2 HUNGRY with free neighbours:
//     node 2 stays HUNGRY; with FAIR_MODE=0 node 2 -> EATING next cycle.
//  5. Reset mid-operation, several nodes EATING/HUNGRY, reset_n=0 one cycle:
//     next st = reset pattern, counters 0.
//  6. Random coin 10k cycles, N=5 and N=16, both modes:
//     excl_err never set, exactly one READING node every cycle.

Source files
------------

// File: rtl/philo_pkg.sv
// Shared definitions for the philosopher ring model.
// Contents:
//   state_t    - 2-bit node state (THINKING=0, READING=1, EATING=2, HUNGRY=3)
//   next_state - per-node transition function from own and neighbour states
package philo_pkg;

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } state_t;

  // left is node (i+1)%N, right is node (i+N-1)%N.
  // yield is already forced low by the caller when fairness is disabled.
  function automatic state_t next_state(
    input state_t self,
    input state_t left,
    input state_t right,
    input logic   coin,
    input logic   yield
  );
    state_t ns;
    ns = self;
    case (self)
      READING: begin
        if (left == THINKING) ns = THINKING;
      end
      THINKING: begin
        // The reading token always moves toward the left neighbour,
        // so an idle node picks it up from its right-hand side.
        if (right == READING) ns = READING;
        else if (!coin)       ns = HUNGRY;
      end
      EATING: begin
        if (coin) ns = THINKING;
      end
      HUNGRY: begin
        // A hungry right neighbour has priority, which keeps two
        // adjacent hungry nodes from starting to eat together.
        if ((left != EATING) && (right != HUNGRY) && (right != EATING) && !yield)
          ns = EATING;
      end
      default: ns = self;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/philo_cell.sv
// One philosopher node: state register, saturating hunger counter and
// starving flag.
// Ports:
//   clock        in  posedge clock
//   reset_n      in  synchronous active-low reset
//   coin         in  nondeterministic choice bit for this node
//   left, right  in  registered states of the neighbours
//   nb_starving  in  {left starving, right starving}
//   init         in  1: node resets to READING, 0: to THINKING
//   st           out registered node state
//   starving     out hunger counter has reached STARVE_LIMIT
module philo_cell
  import philo_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CW           = 4,
  parameter int unsigned FAIR_MODE    = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       coin,
  input  state_t     left,
  input  state_t     right,
  input  logic [1:0] nb_starving,
  input  logic       init,
  output state_t     st,
  output logic       starving
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t          r_st;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_starving;
  logic            w_yield;

  assign w_starving = (r_cnt == LIMIT);

  // A node that is itself starving never yields, so two starving
  // neighbours fall back to the classic arbitration.
  assign w_yield = (FAIR_MODE != 0) && !w_starving && (|nb_starving);

  always_comb begin
    w_next     = next_state(r_st, left, right, coin, w_yield);
    w_cnt_next = '0;
    if ((r_st == HUNGRY) && (w_next == HUNGRY))
      w_cnt_next = w_starving ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_st  <= init ? READING : THINKING;
      r_cnt <= '0;
    end else begin
      r_st  <= w_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign st       = r_st;
  assign starving = w_starving;

endmodule

// File: rtl/philo_ring.sv
// Ring of N philosopher nodes with per-node starvation flags and
// mutual-exclusion error detection.
// Ports:
//   clock     in  posedge clock
//   reset_n   in  synchronous active-low reset
//   coin      in  [N]   per-node nondeterministic choice bits
//   st        out [2N]  node states, st[2i+1:2i] = node i
//   starving  out [N]   node i hunger counter == STARVE_LIMIT
//   excl_err  out [N]   node i and its left neighbour both EATING
module philo_ring
  import philo_pkg::*;
#(
  parameter int unsigned N            = 16,
  parameter int unsigned READER_IDX   = 0,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CW           = 4,
  parameter int unsigned FAIR_MODE    = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] coin,
  output logic [2*N-1:0] st,
  output logic [N-1:0] starving,
  output logic [N-1:0] excl_err
);

  state_t      w_st [N];
  logic [N-1:0] w_starving;

  for (genvar i = 0; i < N; i++) begin : g_cell
    localparam int unsigned LI        = (i + 1) % N;
    localparam int unsigned RI        = (i + N - 1) % N;
    localparam logic        IS_READER = (i == READER_IDX);

    philo_cell #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CW           (CW),
      .FAIR_MODE    (FAIR_MODE)
    ) u_cell (
      .clock        (clock),
      .reset_n      (reset_n),
      .coin         (coin[i]),
      .left         (w_st[LI]),
      .right        (w_st[RI]),
      .nb_starving  ({w_starving[LI], w_starving[RI]}),
      .init         (IS_READER),
      .st           (w_st[i]),
      .starving     (w_starving[i])
    );

    assign st[2*i +: 2] = w_st[i];
    assign excl_err[i]  = (w_st[i] == EATING) && (w_st[LI] == EATING);
  end

  assign starving = w_starving;

endmodule

// File: tb/tb_philo_ring.sv
module tb_philo_ring;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  coin_a;
  logic [4:0]  coin_c, coin_d;
  logic [15:0] coin_e, coin_f;

  logic [7:0]  st_a;  logic [3:0]  sv_a, ex_a;
  logic [9:0]  st_c;  logic [4:0]  sv_c, ex_c;
  logic [9:0]  st_d;  logic [4:0]  sv_d, ex_d;
  logic [31:0] st_e;  logic [15:0] sv_e, ex_e;
  logic [31:0] st_f;  logic [15:0] sv_f, ex_f;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  philo_ring #(.N(4), .READER_IDX(0), .STARVE_LIMIT(3), .CW(4), .FAIR_MODE(0)) u_a (
    .clock(clk), .reset_n(rst_n), .coin(coin_a), .st(st_a), .starving(sv_a), .excl_err(ex_a));
  philo_ring #(.N(5), .READER_IDX(0), .STARVE_LIMIT(3), .CW(4), .FAIR_MODE(0)) u_c (
    .clock(clk), .reset_n(rst_n), .coin(coin_c), .st(st_c), .starving(sv_c), .excl_err(ex_c));
  philo_ring #(.N(5), .READER_IDX(0), .STARVE_LIMIT(3), .CW(4), .FAIR_MODE(1)) u_d (
    .clock(clk), .reset_n(rst_n), .coin(coin_d), .st(st_d), .starving(sv_d), .excl_err(ex_d));
  philo_ring #(.N(16), .READER_IDX(5), .STARVE_LIMIT(8), .CW(4), .FAIR_MODE(0)) u_e (
    .clock(clk), .reset_n(rst_n), .coin(coin_e), .st(st_e), .starving(sv_e), .excl_err(ex_e));
  philo_ring #(.N(16), .READER_IDX(0), .STARVE_LIMIT(8), .CW(4), .FAIR_MODE(1)) u_f (
    .clock(clk), .reset_n(rst_n), .coin(coin_f), .st(st_f), .starving(sv_f), .excl_err(ex_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int readers(input logic [31:0] s, input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (s[2*i +: 2] == 2'b01) c++;
    return c;
  endfunction

  // Directed tables: coin applied before the edge, expected state after it.
  logic [3:0] t3_coin [9] = '{4'b0111, 4'b1110, 4'b0110, 4'b0110, 4'b0110,
                              4'b0110, 4'b0110, 4'b1110, 4'b1110};
  logic [7:0] t3_st   [9] = '{8'hC4, 8'h93, 8'h93, 8'h93, 8'h93,
                              8'h93, 8'h93, 8'h13, 8'h42};
  logic [3:0] t3_sv   [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                              4'h1, 4'h1, 4'h1, 4'h0};

  logic [4:0] t4_coin [12] = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11101, 5'b01111,
                               5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00000};
  logic [9:0] t4_st   [12] = '{10'h004, 10'h010, 10'h040, 10'h100, 10'h00D, 10'h309,
                               10'h2C9, 10'h2C9, 10'h2C9, 10'h2C9, 10'h2C1, 10'h2F4};
  logic [4:0] t4_sv   [12] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                               5'h00, 5'h00, 5'h00, 5'h08, 5'h08, 5'h08};

  initial begin
    rst_n  = 1'b0;
    coin_a = '1; coin_c = '1; coin_d = '1; coin_e = '1; coin_f = '1;

    // Reset for two cycles: reader at READER_IDX, everything else idle.
    step();
    step();
    check("rst_st_a", 32'(st_a), 32'h01);
    check("rst_sv_a", 32'(sv_a), 32'h0);
    check("rst_ex_a", 32'(ex_a), 32'h0);
    check("rst_st_c", 32'(st_c), 32'h001);
    check("rst_st_d", 32'(st_d), 32'h001);
    check("rst_st_e", st_e, 32'h0000_0400);
    check("rst_st_f", st_f, 32'h0000_0001);
    rst_n = 1'b1;

    // Token pass around N=4, wrapping node 3 -> node 0.
    coin_a = 4'b1111;
    step(); check("tok1", 32'(st_a), 32'h04);
    step(); check("tok2", 32'(st_a), 32'h10);
    step(); check("tok3", 32'(st_a), 32'h40);
    step(); check("tok4", 32'(st_a), 32'h01);
    check("tok_sv", 32'(sv_a), 32'h0);

    // Starvation: node 3 held EATING, node 0 HUNGRY, then released.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("starv_rst", 32'(st_a), 32'h01);
    for (int k = 0; k < 9; k++) begin
      coin_a = t3_coin[k];
      step();
      check($sformatf("starv_st%0d", k + 1), 32'(st_a), 32'(t3_st[k]));
      check($sformatf("starv_sv%0d", k + 1), 32'(sv_a), 32'(t3_sv[k]));
      check($sformatf("starv_ex%0d", k + 1), 32'(ex_a), 32'h0);
    end

    // Drive adjacent hungry nodes up to the limit, then reset mid-operation.
    coin_a = 4'b0000;
    step(); check("mid_st1", 32'(st_a), 32'h7E); check("mid_sv1", 32'(sv_a), 32'h0);
    step(); check("mid_st2", 32'(st_a), 32'h7E); check("mid_sv2", 32'(sv_a), 32'h0);
    step(); check("mid_st3", 32'(st_a), 32'h7E); check("mid_sv3", 32'(sv_a), 32'h0);
    step(); check("mid_st4", 32'(st_a), 32'h7E); check("mid_sv4", 32'(sv_a), 32'h6);
    check("mid_ex4", 32'(ex_a), 32'h0);
    rst_n = 1'b0;
    step();
    check("midrst_st", 32'(st_a), 32'h01);
    check("midrst_sv", 32'(sv_a), 32'h0);
    check("midrst_ex", 32'(ex_a), 32'h0);
    rst_n = 1'b1;

    // Fairness: node 3 starving, node 2 hungry with a free right side.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      coin_c = t4_coin[k];
      coin_d = t4_coin[k];
      step();
      check($sformatf("fair0_st%0d", k + 1), 32'(st_c), 32'(t4_st[k]));
      check($sformatf("fair1_st%0d", k + 1), 32'(st_d), 32'(t4_st[k]));
      check($sformatf("fair1_sv%0d", k + 1), 32'(sv_d), 32'(t4_sv[k]));
    end
    coin_c = 5'b00001;
    coin_d = 5'b00001;
    step();
    check("fair0_eat",  32'(st_c), 32'h2E4);
    check("fair1_hold", 32'(st_d), 32'h2F4);
    check("fair0_sv",   32'(sv_c), 32'h08);
    check("fair1_sv",   32'(sv_d), 32'h08);
    check("fair0_ex",   32'(ex_c), 32'h0);

    // Random coins: safety invariants on every ring, every cycle.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      coin_a = 4'($urandom);
      coin_c = 5'($urandom);
      coin_d = 5'($urandom);
      coin_e = 16'($urandom);
      coin_f = 16'($urandom);
      step();
      check("rnd_ex_a", 32'(ex_a), 32'h0);
      check("rnd_ex_c", 32'(ex_c), 32'h0);
      check("rnd_ex_d", 32'(ex_d), 32'h0);
      check("rnd_ex_e", 32'(ex_e), 32'h0);
      check("rnd_ex_f", 32'(ex_f), 32'h0);
      check("rnd_rd_a", 32'(readers(32'(st_a), 4)),  32'd1);
      check("rnd_rd_c", 32'(readers(32'(st_c), 5)),  32'd1);
      check("rnd_rd_d", 32'(readers(32'(st_d), 5)),  32'd1);
      check("rnd_rd_e", 32'(readers(st_e, 16)), 32'd1);
      check("rnd_rd_f", 32'(readers(st_f, 16)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
